// File: rtl/thora_pkg.sv
// Shared types and constants for the hour-set stage of the timer.
package thora_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_t;

    localparam logic [3:0] HOUR_MAX_DEC = 4'h2;
    localparam logic [3:0] HOUR_MAX_UNI = 4'h3;

endpackage

// File: rtl/bcd_hour_step.sv
// Combinational one-hour step on a two-digit BCD hour, wrapping 23 <-> 00.
module bcd_hour_step
    import thora_pkg::*;
(
    input  logic [3:0] i_dec,
    input  logic [3:0] i_uni,
    input  dir_t       i_dir,
    output logic [3:0] o_dec,
    output logic [3:0] o_uni
);

    always_comb begin
        o_dec = i_dec;
        o_uni = i_uni;
        if (i_dir == UP) begin
            if (i_dec == HOUR_MAX_DEC && i_uni == HOUR_MAX_UNI) begin
                o_dec = 4'd0;
                o_uni = 4'd0;
            end else if (i_uni == 4'd9) begin
                o_dec = i_dec + 4'd1;
                o_uni = 4'd0;
            end else begin
                o_uni = i_uni + 4'd1;
            end
        end else begin
            if (i_dec == 4'd0 && i_uni == 4'd0) begin
                o_dec = HOUR_MAX_DEC;
                o_uni = HOUR_MAX_UNI;
            end else if (i_uni == 4'd0) begin
                o_dec = i_dec - 4'd1;
                o_uni = 4'd9;
            end else begin
                o_uni = i_uni - 4'd1;
            end
        end
    end

endmodule

// File: rtl/thora_hour_setter.sv
// Hour-set stage: steps a BCD hour 00..23 from debounced buttons with hold-to-repeat.
module thora_hour_setter
    import thora_pkg::*;
#(
    parameter int HOLD_TICKS = 500,
    parameter int RPT_TICKS  = 100,
    parameter int CNT_W      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       clear,
    output logic [3:0] code_dec,
    output logic [3:0] code_uni,
    output logic       changed,
    output state_t     o_dbg_state
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_TICKS - 1);

    state_t           r_state;
    dir_t             r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_dec;
    logic [3:0]       r_uni;
    logic             r_changed;
    logic             r_btn_up_q;
    logic             r_btn_dn_q;
    logic             r_armed;

    state_t           w_state_nxt;
    dir_t             w_dir_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_step;
    logic             w_up_rise;
    logic             w_dn_rise;
    logic             w_dir_btn;
    logic             w_other_btn;
    logic [CNT_W-1:0] w_last;
    logic [3:0]       w_dec_nxt;
    logic [3:0]       w_uni_nxt;

    // A button held through reset must be released (both low) before any edge counts.
    assign w_up_rise   = btn_up & ~r_btn_up_q & r_armed;
    assign w_dn_rise   = btn_dn & ~r_btn_dn_q & r_armed;
    assign w_dir_btn   = (r_dir == UP) ? btn_up : btn_dn;
    assign w_other_btn = (r_dir == UP) ? btn_dn : btn_up;
    assign w_last      = (r_state == HOLD) ? HOLD_LAST : RPT_LAST;

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_step      = 1'b0;
        if (clear || !en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_up_rise ^ w_dn_rise) begin
                        w_step      = 1'b1;
                        w_dir_nxt   = w_up_rise ? UP : DN;
                        w_cnt_nxt   = '0;
                        w_state_nxt = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (!w_dir_btn || w_other_btn) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (tick) begin
                        if (r_cnt == w_last) begin
                            w_step      = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = REPEAT;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    bcd_hour_step u_step (
        .i_dec (r_dec),
        .i_uni (r_uni),
        .i_dir (w_dir_nxt),
        .o_dec (w_dec_nxt),
        .o_uni (w_uni_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dir      <= UP;
            r_cnt      <= '0;
            r_dec      <= 4'd0;
            r_uni      <= 4'd0;
            r_changed  <= 1'b0;
            r_btn_up_q <= 1'b0;
            r_btn_dn_q <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_btn_up_q <= btn_up;
            r_btn_dn_q <= btn_dn;
            r_armed    <= r_armed | (~btn_up & ~btn_dn);
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_cnt      <= w_cnt_nxt;
            if (clear) begin
                r_dec     <= 4'd0;
                r_uni     <= 4'd0;
                r_changed <= (r_dec != 4'd0) || (r_uni != 4'd0);
            end else if (w_step) begin
                r_dec     <= w_dec_nxt;
                r_uni     <= w_uni_nxt;
                r_changed <= 1'b1;
            end else begin
                r_changed <= 1'b0;
            end
        end
    end

    assign code_dec    = r_dec;
    assign code_uni    = r_uni;
    assign changed     = r_changed;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_thora_hour_setter.sv
// Directed bench for the hour-set stage and its standalone BCD step function.
module tb_thora_hour_setter;
    import thora_pkg::*;

    logic       clk = 1'b0;
    logic       reset, en, tick, btn_up, btn_dn, clear;
    logic [3:0] code_dec, code_uni;
    logic       changed;
    state_t     dbg_state;
    logic [8:0] obs;

    logic [3:0] s_dec, s_uni, s_odec, s_ouni;
    dir_t       s_dir;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    thora_hour_setter #(.HOLD_TICKS(4), .RPT_TICKS(2), .CNT_W(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .tick        (tick),
        .btn_up      (btn_up),
        .btn_dn      (btn_dn),
        .clear       (clear),
        .code_dec    (code_dec),
        .code_uni    (code_uni),
        .changed     (changed),
        .o_dbg_state (dbg_state)
    );

    bcd_hour_step u_bcd (
        .i_dec (s_dec),
        .i_uni (s_uni),
        .i_dir (s_dir),
        .o_dec (s_odec),
        .o_uni (s_ouni)
    );

    // {changed, tens, units}: 9'h106 reads as "pulse, hour 06".
    assign obs = {changed, code_dec, code_uni};

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step_clk();
    endtask

    task automatic drive_btn(input logic up, input logic dn);
        btn_up = up;
        btn_dn = dn;
        step_clk();
    endtask

    // One tick per three clocks: the tick edge, then two quiet cycles.
    task automatic tick_pulse();
        tick = 1'b1;
        step_clk();
        tick = 1'b0;
        idle(2);
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; tick = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; clear = 1'b0;
        idle(2);
        n_vec++;
        if (obs !== 9'h000) begin n_bad++; $display("FAIL reset_value: got %h want %h", obs, 9'h000); end
        n_vec++;
        if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_single_steps();
        logic [8:0] exp_v;
        for (int i = 1; i <= 3; i++) begin
            drive_btn(1'b1, 1'b0);
            exp_v = 9'h100 | 9'(i);
            n_vec++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL up_pulse_%0d: got %h want %h", i, obs, exp_v); end
            drive_btn(1'b0, 1'b0);
            exp_v = 9'(i);
            n_vec++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL up_settle_%0d: got %h want %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_wrap();
        logic [8:0] exp_v;
        for (int h = 4; h <= 23; h++) begin
            drive_btn(1'b1, 1'b0);
            exp_v = {1'b1, 4'(h / 10), 4'(h % 10)};
            n_vec++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL load_up_%0d: got %h want %h", h, obs, exp_v); end
            drive_btn(1'b0, 1'b0);
        end
        drive_btn(1'b1, 1'b0);
        n_vec++;
        if (obs !== 9'h100) begin n_bad++; $display("FAIL wrap_23_00: got %h want %h", obs, 9'h100); end
        drive_btn(1'b0, 1'b0);
        drive_btn(1'b0, 1'b1);
        n_vec++;
        if (obs !== 9'h123) begin n_bad++; $display("FAIL wrap_00_23: got %h want %h", obs, 9'h123); end
        drive_btn(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_btn(1'b0, 1'b1);
            drive_btn(1'b0, 1'b0);
        end
        n_vec++;
        if (obs !== 9'h020) begin n_bad++; $display("FAIL at_20: got %h want %h", obs, 9'h020); end
        drive_btn(1'b0, 1'b1);
        n_vec++;
        if (obs !== 9'h119) begin n_bad++; $display("FAIL dn_20_19: got %h want %h", obs, 9'h119); end
        drive_btn(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            drive_btn(1'b0, 1'b1);
            drive_btn(1'b0, 1'b0);
        end
        drive_btn(1'b0, 1'b1);
        n_vec++;
        if (obs !== 9'h109) begin n_bad++; $display("FAIL dn_10_09: got %h want %h", obs, 9'h109); end
        drive_btn(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_btn(1'b0, 1'b1);
            drive_btn(1'b0, 1'b0);
        end
        n_vec++;
        if (obs !== 9'h005) begin n_bad++; $display("FAIL at_05: got %h want %h", obs, 9'h005); end
    endtask

    task automatic test_hold_repeat();
        logic [8:0] exp_v;
        // Tick coincides with the first-step edge and must not count.
        btn_up = 1'b1;
        tick   = 1'b1;
        step_clk();
        tick   = 1'b0;
        n_vec++;
        if (obs !== 9'h106) begin n_bad++; $display("FAIL hold_first: got %h want %h", obs, 9'h106); end
        idle(2);
        for (int t = 1; t <= 3; t++) begin
            tick_pulse();
            n_vec++;
            if (obs !== 9'h006) begin n_bad++; $display("FAIL hold_wait_%0d: got %h want %h", t, obs, 9'h006); end
        end
        tick = 1'b1;
        step_clk();
        tick = 1'b0;
        n_vec++;
        if (obs !== 9'h107) begin n_bad++; $display("FAIL hold_4th: got %h want %h", obs, 9'h107); end
        n_vec++;
        if (dbg_state !== REPEAT) begin n_bad++; $display("FAIL hold_to_repeat: got %0d want %0d", dbg_state, REPEAT); end
        idle(2);
        for (int h = 8; h <= 10; h++) begin
            tick_pulse();
            exp_v = {1'b0, 4'(h / 10), 4'((h - 1) % 10)};
            if (h == 10) exp_v = 9'h009;
            n_vec++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL rpt_wait_%0d: got %h want %h", h, obs, exp_v); end
            tick = 1'b1;
            step_clk();
            tick = 1'b0;
            exp_v = {1'b1, 4'(h / 10), 4'(h % 10)};
            n_vec++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL rpt_step_%0d: got %h want %h", h, obs, exp_v); end
            idle(2);
        end
        drive_btn(1'b0, 1'b0);
        for (int t = 0; t < 4; t++) tick_pulse();
        n_vec++;
        if (obs !== 9'h010) begin n_bad++; $display("FAIL release_stop: got %h want %h", obs, 9'h010); end
    endtask

    task automatic test_both_and_abort();
        drive_btn(1'b1, 1'b1);
        n_vec++;
        if (obs !== 9'h010) begin n_bad++; $display("FAIL both_rise: got %h want %h", obs, 9'h010); end
        n_vec++;
        if (dbg_state !== IDLE) begin n_bad++; $display("FAIL both_rise_state: got %0d want %0d", dbg_state, IDLE); end
        drive_btn(1'b0, 1'b0);
        drive_btn(1'b1, 1'b0);
        idle(2);
        for (int t = 0; t < 4; t++) tick_pulse();
        n_vec++;
        if (obs !== 9'h012 || dbg_state !== REPEAT) begin
            n_bad++; $display("FAIL abort_setup: got %h/%0d want %h/%0d", obs, dbg_state, 9'h012, REPEAT);
        end
        drive_btn(1'b1, 1'b1);
        n_vec++;
        if (obs !== 9'h012 || dbg_state !== IDLE) begin
            n_bad++; $display("FAIL abort_dn: got %h/%0d want %h/%0d", obs, dbg_state, 9'h012, IDLE);
        end
        tick_pulse();
        n_vec++;
        if (obs !== 9'h012) begin n_bad++; $display("FAIL abort_tick: got %h want %h", obs, 9'h012); end
        drive_btn(1'b0, 1'b0);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 2; i++) begin
            drive_btn(1'b1, 1'b0);
            drive_btn(1'b0, 1'b0);
        end
        n_vec++;
        if (obs !== 9'h014) begin n_bad++; $display("FAIL at_14: got %h want %h", obs, 9'h014); end
        clear = 1'b1;
        step_clk();
        clear = 1'b0;
        n_vec++;
        if (obs !== 9'h100) begin n_bad++; $display("FAIL clear_14: got %h want %h", obs, 9'h100); end
        step_clk();
        clear = 1'b1;
        step_clk();
        clear = 1'b0;
        n_vec++;
        if (obs !== 9'h000) begin n_bad++; $display("FAIL clear_00: got %h want %h", obs, 9'h000); end
        drive_btn(1'b1, 1'b0);
        drive_btn(1'b0, 1'b0);
        btn_up = 1'b1;
        clear  = 1'b1;
        step_clk();
        clear  = 1'b0;
        n_vec++;
        if (obs !== 9'h100 || dbg_state !== IDLE) begin
            n_bad++; $display("FAIL clear_vs_up: got %h/%0d want %h/%0d", obs, dbg_state, 9'h100, IDLE);
        end
        step_clk();
        n_vec++;
        if (obs !== 9'h000) begin n_bad++; $display("FAIL clear_vs_up_hold: got %h want %h", obs, 9'h000); end
        drive_btn(1'b0, 1'b0);
    endtask

    task automatic test_enable();
        en = 1'b0;
        drive_btn(1'b1, 1'b0);
        tick_pulse();
        drive_btn(1'b0, 1'b0);
        drive_btn(1'b0, 1'b1);
        n_vec++;
        if (obs !== 9'h000 || dbg_state !== IDLE) begin
            n_bad++; $display("FAIL en_low_frozen: got %h/%0d want %h/%0d", obs, dbg_state, 9'h000, IDLE);
        end
        drive_btn(1'b0, 1'b0);
        en = 1'b1;
        step_clk();
    endtask

    task automatic test_reset_mid_repeat();
        drive_btn(1'b1, 1'b0);
        idle(2);
        for (int t = 0; t < 6; t++) tick_pulse();
        n_vec++;
        if (obs !== 9'h003 || dbg_state !== REPEAT) begin
            n_bad++; $display("FAIL pre_reset: got %h/%0d want %h/%0d", obs, dbg_state, 9'h003, REPEAT);
        end
        reset = 1'b1;
        step_clk();
        n_vec++;
        if (obs !== 9'h000 || dbg_state !== IDLE) begin
            n_bad++; $display("FAIL mid_reset: got %h/%0d want %h/%0d", obs, dbg_state, 9'h000, IDLE);
        end
        reset = 1'b0;
        step_clk();
        for (int t = 0; t < 4; t++) tick_pulse();
        n_vec++;
        if (obs !== 9'h000 || dbg_state !== IDLE) begin
            n_bad++; $display("FAIL held_after_reset: got %h/%0d want %h/%0d", obs, dbg_state, 9'h000, IDLE);
        end
        drive_btn(1'b0, 1'b0);
        drive_btn(1'b1, 1'b0);
        n_vec++;
        if (obs !== 9'h101) begin n_bad++; $display("FAIL repress: got %h want %h", obs, 9'h101); end
        drive_btn(1'b0, 1'b0);
    endtask

    task automatic test_bcd_step();
        int nh;
        logic [3:0] exp_dec, exp_uni;
        for (int h = 0; h < 24; h++) begin
            for (int d = 0; d < 2; d++) begin
                s_dec = 4'(h / 10);
                s_uni = 4'(h % 10);
                s_dir = (d == 0) ? UP : DN;
                #1;
                nh = (d == 0) ? (h + 1) % 24 : (h + 23) % 24;
                exp_dec = 4'(nh / 10);
                exp_uni = 4'(nh % 10);
                n_vec++;
                if (s_odec !== exp_dec || s_ouni !== exp_uni) begin
                    n_bad++;
                    $display("FAIL bcd_step_%0d_%0d: got %h%h want %h%h", h, d, s_odec, s_ouni, exp_dec, exp_uni);
                end
            end
        end
    endtask

    initial begin
        s_dec = 4'd0; s_uni = 4'd0; s_dir = UP;
        test_reset();
        test_single_steps();
        test_wrap();
        test_hold_repeat();
        test_both_and_abort();
        test_clear();
        test_enable();
        test_reset_mid_repeat();
        test_bcd_step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
